// File: rtl/muldiv_hilo_pkg.sv
// muldiv_hilo_pkg: shared types and constants for the HI/LO multiply-divide unit.
//   size_t       : 32-bit datapath word
//   muldiv_op_t  : operation select driven by the core's decode stage
//   md_state_e   : multiply-divide sequencer states
package muldiv_hilo_pkg;

    typedef logic [31:0] size_t;

    typedef enum logic [2:0] {
        MD_NONE,
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU,
        MD_MTHI,
        MD_MTLO
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StFix
    } md_state_e;

    localparam int unsigned DIV_ITERATIONS = 32;

    // Two's-complement magnitude when en is set, raw value otherwise.
    function automatic size_t abs_if(input logic en, input size_t v);
        return (en && v[31]) ? size_t'(-v) : v;
    endfunction

endpackage

// File: rtl/muldiv_hilo_divu_iter.sv
// muldiv_hilo_divu_iter: iterative unsigned restoring divider, one quotient bit per clock.
//   clk, reset_n_i : clock, asynchronous active-low reset
//   load           : capture dividend/divisor and start DIV_ITERATIONS iterations
//   dividend       : unsigned dividend
//   divisor        : unsigned divisor (zero yields quotient all-ones, remainder = dividend)
//   quotient       : quotient, valid after the last iteration until the next load
//   remainder      : remainder, valid alongside quotient
//   last_iter      : high in the cycle whose closing edge performs the final iteration
module muldiv_hilo_divu_iter
    import muldiv_hilo_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             reset_n_i,
    input  logic             load,
    input  logic [Width-1:0] dividend,
    input  logic [Width-1:0] divisor,
    output logic [Width-1:0] quotient,
    output logic [Width-1:0] remainder,
    output logic             last_iter
);

    localparam int unsigned     CntW    = $clog2(DIV_ITERATIONS);
    localparam logic [CntW-1:0] LastCnt = CntW'(DIV_ITERATIONS - 1);

    logic [Width-1:0] rem_q, rem_d;
    logic [Width-1:0] quo_q, quo_d;
    logic [Width-1:0] dsr_q, dsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             active_q, active_d;

    logic [Width:0]   shl;
    logic [Width-1:0] diff;
    logic             ge;

    always_comb begin
        // {rem, quo} shifted left by one; the top quotient bit enters the remainder.
        shl  = {rem_q, quo_q[Width-1]};
        ge   = shl >= {1'b0, dsr_q};
        // Only used when ge, where the true difference is below the divisor and fits Width bits.
        diff = shl[Width-1:0] - dsr_q;

        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        active_d = active_q;

        if (load) begin
            rem_d    = '0;
            quo_d    = dividend;
            dsr_d    = divisor;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            rem_d = ge ? diff : shl[Width-1:0];
            quo_d = {quo_q[Width-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last_iter = active_q && (cnt_q == LastCnt);

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: MIPS HI/LO multiply-divide unit holding the architectural HI and LO registers.
//   clk         : core clock
//   reset_n_i   : asynchronous active-low reset (aborts any divide)
//   op_valid_i  : request strobe; dropped while busy_o is high
//   op_i        : MULT/MULTU/DIV/DIVU/MTHI/MTLO select
//   rs_data_i   : dividend / multiplicand / MTHI-MTLO source
//   rt_data_i   : divisor / multiplier
//   hi_o, lo_o  : architectural HI and LO
//   busy_o      : divide in progress, HI/LO not yet updated
//   done_o      : one-cycle pulse after HI/LO were written
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic       op_valid_i,
    input  muldiv_op_t op_i,
    input  size_t      rs_data_i,
    input  size_t      rt_data_i,
    output size_t      hi_o,
    output size_t      lo_o,
    output logic       busy_o,
    output logic       done_o
);

    md_state_e state_q, state_d;
    size_t     hi_q, hi_d;
    size_t     lo_q, lo_d;
    logic      done_q, done_d;
    logic      q_neg_q, q_neg_d;
    logic      r_neg_q, r_neg_d;
    logic      dz_q, dz_d;
    size_t     rs_orig_q, rs_orig_d;

    logic        accept;
    logic        is_div;
    logic        div_load;
    size_t       dvd_mag;
    size_t       dsr_mag;
    size_t       div_quo;
    size_t       div_rem;
    logic        div_last;
    logic        mul_sx;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;

    assign accept = op_valid_i && (state_q == StIdle) && (op_i != MD_NONE);
    assign is_div = (op_i == MD_DIV);

    // Sign/zero-extend once and keep the low 64 bits: one multiplier serves MULT and MULTU.
    assign mul_sx = (op_i == MD_MULT);
    assign mul_a  = {{32{mul_sx & rs_data_i[31]}}, rs_data_i};
    assign mul_b  = {{32{mul_sx & rt_data_i[31]}}, rt_data_i};
    assign prod   = mul_a * mul_b;

    assign dvd_mag = abs_if(is_div, rs_data_i);
    assign dsr_mag = abs_if(is_div, rt_data_i);

    muldiv_hilo_divu_iter #(
        .Width(WIDTH)
    ) u_divu_iter (
        .clk      (clk),
        .reset_n_i(reset_n_i),
        .load     (div_load),
        .dividend (dvd_mag),
        .divisor  (dsr_mag),
        .quotient (div_quo),
        .remainder(div_rem),
        .last_iter(div_last)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dz_d      = dz_q;
        rs_orig_d = rs_orig_q;
        div_load  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (op_i)
                        MD_MULT, MD_MULTU: begin
                            {hi_d, lo_d} = prod;
                            done_d       = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            div_load  = 1'b1;
                            q_neg_d   = is_div & (rs_data_i[31] ^ rt_data_i[31]);
                            r_neg_d   = is_div & rs_data_i[31];
                            dz_d      = (rt_data_i == '0);
                            rs_orig_d = rs_data_i;
                            state_d   = StDiv;
                        end
                        MD_MTHI: begin
                            hi_d   = rs_data_i;
                            done_d = 1'b1;
                        end
                        MD_MTLO: begin
                            lo_d   = rs_data_i;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StDiv: begin
                if (div_last) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dz_q) begin
                    hi_d = rs_orig_q;
                    lo_d = '1;
                end else begin
                    // Truncating division: quotient sign from operands, remainder follows dividend.
                    lo_d = q_neg_q ? size_t'(-div_quo) : div_quo;
                    hi_d = r_neg_q ? size_t'(-div_rem) : div_rem;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dz_q      <= 1'b0;
            rs_orig_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            dz_q      <= dz_d;
            rs_orig_q <= rs_orig_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed and randomized checks of muldiv_hilo against an arithmetic model.
module tb_muldiv_hilo;
    import muldiv_hilo_pkg::*;

    logic       clk        = 1'b0;
    logic       reset_n_i  = 1'b0;
    logic       op_valid_i = 1'b0;
    muldiv_op_t op_i       = MD_NONE;
    size_t      rs_data_i  = '0;
    size_t      rt_data_i  = '0;
    size_t      hi_o;
    size_t      lo_o;
    logic       busy_o;
    logic       done_o;

    int n_pass   = 0;
    int n_total  = 0;
    int done_cnt = 0;

    muldiv_hilo dut (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .op_valid_i(op_valid_i),
        .op_i      (op_i),
        .rs_data_i (rs_data_i),
        .rt_data_i (rt_data_i),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Returns {hi, lo} for a divide, by plain 64-bit arithmetic (C truncation).
    function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural model: HI/LO values, remaining busy cycles, pending divide result.
    size_t       m_hi   = '0;
    size_t       m_lo   = '0;
    int          m_busy = 0;
    logic        m_done = 1'b0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge reset_n_i) begin
        longint sa, sb;
        logic [63:0] p;
        if (!reset_n_i) begin
            m_hi   = '0;
            m_lo   = '0;
            m_busy = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy != 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done       = 1'b1;
                end
            end else if (op_valid_i && op_i != MD_NONE) begin
                case (op_i)
                    MD_MULT: begin
                        sa = longint'($signed(rs_data_i));
                        sb = longint'($signed(rt_data_i));
                        p  = 64'(sa * sb);
                        {m_hi, m_lo} = p;
                        m_done = 1'b1;
                    end
                    MD_MULTU: begin
                        sa = longint'({32'h0, rs_data_i});
                        sb = longint'({32'h0, rt_data_i});
                        p  = 64'(sa * sb);
                        {m_hi, m_lo} = p;
                        m_done = 1'b1;
                    end
                    MD_DIV: begin
                        m_pend = div_ref(1'b1, rs_data_i, rt_data_i);
                        m_busy = 33;
                    end
                    MD_DIVU: begin
                        m_pend = div_ref(1'b0, rs_data_i, rt_data_i);
                        m_busy = 33;
                    end
                    MD_MTHI: begin
                        m_hi   = rs_data_i;
                        m_done = 1'b1;
                    end
                    MD_MTLO: begin
                        m_lo   = rs_data_i;
                        m_done = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_hi", hi_o, m_hi);
        chk("cyc_lo", lo_o, m_lo);
        chk("cyc_busy", 32'(busy_o), 32'(m_busy != 0));
        chk("cyc_done", 32'(done_o), 32'(m_done));
        if (done_o) done_cnt++;
    end

    task automatic issue(input muldiv_op_t op, input size_t rs, input size_t rt);
        @(posedge clk);
        #1;
        op_valid_i = 1'b1;
        op_i       = op;
        rs_data_i  = rs;
        rt_data_i  = rt;
        @(posedge clk);
        #1;
        op_valid_i = 1'b0;
        op_i       = MD_NONE;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_o) break;
            cycles++;
        end
    endtask

    function automatic size_t pick_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return size_t'($urandom_range(0, 20));
            default: return size_t'($urandom);
        endcase
    endfunction

    initial begin
        int cyc;
        int d0;

        // Reset state
        @(negedge clk);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        #2 reset_n_i = 1'b1;

        // MULT / MULTU
        issue(MD_MULT, 32'hFFFF_FFFE, 32'h3);
        @(negedge clk);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFFA);
        chk("mult_done", 32'(done_o), 32'h1);
        @(negedge clk);
        chk("mult_done_drop", 32'(done_o), 32'h0);
        issue(MD_MULTU, 32'hFFFF_FFFE, 32'h3);
        @(negedge clk);
        chk("multu_hi", hi_o, 32'h2);
        chk("multu_lo", lo_o, 32'hFFFF_FFFA);

        // DIV -7 / 2
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h2);
        wait_idle(cyc);
        chk("div_busy_cycles", cyc, 33);
        chk("div_done", 32'(done_o), 32'h1);
        chk("div_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_hi", hi_o, 32'hFFFF_FFFF);

        issue(MD_DIVU, 32'd100, 32'd7);
        wait_idle(cyc);
        chk("divu_lo", lo_o, 32'd14);
        chk("divu_hi", hi_o, 32'd2);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        chk("ovf_lo", lo_o, 32'h8000_0000);
        chk("ovf_hi", hi_o, 32'h0);

        issue(MD_DIVU, 32'd5, 32'h0);
        wait_idle(cyc);
        chk("divu0_busy_cycles", cyc, 33);
        chk("divu0_hi", hi_o, 32'd5);
        chk("divu0_lo", lo_o, 32'hFFFF_FFFF);

        issue(MD_DIV, 32'h8000_0000, 32'h0);
        wait_idle(cyc);
        chk("div0_hi", hi_o, 32'h8000_0000);
        chk("div0_lo", lo_o, 32'hFFFF_FFFF);

        // Requests while busy are dropped
        @(posedge clk);
        #1 d0 = done_cnt;
        issue(MD_DIVU, 32'd1000, 32'd9);
        issue(MD_MTHI, 32'h1234, 32'h0);
        issue(MD_MULT, 32'd2, 32'd3);
        wait_idle(cyc);
        chk("drop_hi", hi_o, 32'd1);
        chk("drop_lo", lo_o, 32'd111);
        @(posedge clk);
        #1 chk("drop_done_pulses", done_cnt - d0, 1);

        // Back-to-back MTLO then MTHI
        @(posedge clk);
        #1;
        op_valid_i = 1'b1;
        op_i       = MD_MTLO;
        rs_data_i  = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        op_i      = MD_MTHI;
        rs_data_i = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("bb_done1", 32'(done_o), 32'h1);
        chk("bb_lo1", lo_o, 32'hAAAA_5555);
        @(posedge clk);
        #1;
        op_valid_i = 1'b0;
        op_i       = MD_NONE;
        @(negedge clk);
        chk("bb_done2", 32'(done_o), 32'h1);
        chk("bb_hi", hi_o, 32'h0F0F_0F0F);
        chk("bb_lo", lo_o, 32'hAAAA_5555);
        @(negedge clk);
        chk("bb_done_drop", 32'(done_o), 32'h0);

        // Asynchronous reset mid-divide
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #3 reset_n_i = 1'b0;
        #1;
        chk("arst_hi", hi_o, 32'h0);
        chk("arst_lo", lo_o, 32'h0);
        chk("arst_busy", 32'(busy_o), 32'h0);
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #3 reset_n_i = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_idle", 32'(busy_o), 32'h0);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            op_valid_i = ($urandom_range(0, 9) < 7);
            op_i       = muldiv_op_t'($urandom_range(1, 6));
            rs_data_i  = pick_word();
            rt_data_i  = pick_word();
        end
        @(posedge clk);
        #1;
        op_valid_i = 1'b0;
        op_i       = MD_NONE;
        repeat (40) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- HI/LO multiply-divide unit for the MIPS core, directly downstream of the register file.
- Consumes the two register-file read ports (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI and LO registers.
- The core's MFHI/MFLO path reads hi_o and lo_o.
- Multiply completes in one edge; divide is a 33-cycle iterative operation with a busy handshake that the core uses to stall.

Parameters:
- WIDTH, 32, datapath width. Must equal $bits(size_t); no other value is supported.

Ports:
- clk  input  1  core clock
- reset_n_i  input  1  asynchronous active-low reset
- op_valid_i  input  1  request strobe, sampled on the rising edge of clk
- op_i  input  muldiv_op_t (3)  operation select
- rs_data_i  input  size_t (32)  rs operand (dividend / multiplicand / MTHI, MTLO source)
- rt_data_i  input  size_t (32)  rt operand (divisor / multiplier)
- hi_o  output  size_t (32)  architectural HI
- lo_o  output  size_t (32)  architectural LO
- busy_o  output  1  divide in progress; HI/LO not valid
- done_o  output  1  one-cycle pulse when HI/LO have been updated

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (reset_n_i low, any time, including mid-divide):
  - hi_o = 0, lo_o = 0, busy_o = 0, done_o = 0.
  - State returns to IDLE; any in-flight divide is aborted.
- Acceptance: a request is accepted at an edge where op_valid_i = 1, state = IDLE and op_i != MD_NONE.
- Ignored requests: while busy, op_valid_i is ignored entirely, including MTHI/MTLO. The request is dropped; the core must stall.
- States: IDLE, DIV, FIX. busy_o = (state != IDLE).
- MULT / MULTU:
  - {HI, LO} is written with the 64-bit product at the accepting edge.
  - MULT uses signed operands; MULTU uses unsigned operands.
  - done_o = 1 in the following cycle. State stays IDLE.
- MTHI / MTLO:
  - HI (resp. LO) <= rs_data_i at the accepting edge; the other register is unchanged.
  - done_o pulses in the following cycle.
- DIV / DIVU, accepting edge E0:
  - Latch magnitudes: absolute values for DIV, raw values for DIVU.
  - Latch the quotient-sign flag (rs[31]^rt[31], DIV only) and the remainder-sign flag (rs[31], DIV only).
  - Latch the original rs. Clear the iteration counter. State goes to DIV.
- Iterations, edges E1..E32: one restoring-division iteration per edge, MSB first; 64-bit partial remainder/quotient shift register. After E32, state goes to FIX.
- Edge E33 (leaving FIX):
  - LO <= quotient, HI <= remainder, with sign correction applied for DIV.
  - State goes to IDLE. done_o = 1 for the one cycle after E33.
  - busy_o is therefore high for exactly 33 cycles (after E0 through E33).
- Divide-by-zero (rt = 0), both signed and unsigned: HI = original rs, LO = 0xFFFFFFFF. Timing is still 33 busy cycles.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No exception.
- Sign rules for DIV: quotient negated iff the quotient-sign flag is set; remainder takes the dividend's sign; C truncation toward zero.
- During DIV and FIX, hi_o and lo_o keep their previous values until E33.
- done_o is 0 in every cycle other than the pulses defined above.

Decomposition:
- Package codes:
  - typedef enum logic[2:0] muldiv_op_t {MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO}
  - localparam DIV_ITERATIONS = 32
  - size_t is reused.
- Sub-module divu_iter: iterative unsigned restoring divider.
  - Inputs: clk, reset_n_i, load, dividend, divisor.
  - Outputs: quotient, remainder, last_iter.
  - The parent owns sign handling, the FSM, and HI/LO.

Test Plan:
- Reset mid-divide: accept DIVU 100/7, assert reset_n_i low at cycle 10 -> hi_o = lo_o = 0, busy_o = 0 immediately (asynchronous). No done_o pulse afterwards.
- MULT 0xFFFFFFFE × 3 -> next cycle HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, done_o = 1 for one cycle. MULTU with the same operands -> HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV -7 / 2 -> busy_o high exactly 33 cycles, then LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIVU 100 / 7 -> LO = 14, HI = 2.
- Boundaries:
  - DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
  - DIVU 5 / 0 -> HI = 5, LO = 0xFFFFFFFF.
  - DIV 0x80000000 / 0 -> HI = 0x80000000, LO = 0xFFFFFFFF.
- Request while busy: during a DIVU, issue MTHI with rs = 0x1234 and MULT 2×3 -> both dropped. Final HI/LO equal the divide result. Only one done_o pulse.
- Back-to-back: MTLO 0xAAAA5555, then MTHI 0x0F0F0F0F on the next edge -> LO = 0xAAAA5555, HI = 0x0F0F0F0F, done_o high two consecutive cycles.
